// File: rtl/uart_pkg.sv
// Shared types and constants for the 8N1 UART transmitter slice.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_e;

   localparam int UART_DATA_BITS  = 8;
   localparam int UART_FRAME_BITS = 10;
   localparam int UART_MIN_DIV    = 2;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Byte push handshake between a producer and the UART transmit FIFO.
interface uart_tx_fifo_if;

   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;

   modport master (output tx_data, output tx_valid, input tx_ready);
   modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/uart_byte_fifo.sv
// Small synchronous byte FIFO. The level counter has one bit more than the
// pointers so that a full FIFO and an empty FIFO are distinguishable.
module uart_byte_fifo #(
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        push,
   input  logic [7:0]  wdata,
   input  logic        pop,
   output logic [7:0]  rdata,
   output logic        full,
   output logic        empty,
   output logic [AW:0] level
);

   logic [7:0]    mem_q [DEPTH];
   logic [7:0]    mem_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          push_ok_s;
   logic          pop_ok_s;

   assign full      = (count_q == (AW+1)'(DEPTH));
   assign empty     = (count_q == (AW+1)'(0));
   assign level     = count_q;
   assign rdata     = mem_q[rd_ptr_q];
   assign push_ok_s = push && !full;
   assign pop_ok_s  = pop && !empty;

   // Next-state of storage, pointers and occupancy; pointers wrap naturally.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok_s) begin
         mem_d[wr_ptr_q] = wdata;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_ok_s) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      if (push_ok_s && !pop_ok_s) begin
         count_d = count_q + (AW+1)'(1);
      end else if (pop_ok_s && !push_ok_s) begin
         count_d = count_q - (AW+1)'(1);
      end else begin
         count_d = count_q;
      end
   end

   // FIFO state registers; reset flushes contents and pointers.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= 8'h00;
         end
         wr_ptr_q <= AW'(0);
         rd_ptr_q <= AW'(0);
         count_q  <= (AW+1)'(0);
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter with a byte FIFO in front. Bytes go out LSB first;
// the next frame starts straight after a stop bit when data is waiting.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int DIV_W = 16
) (
   input  logic                     wb_clk_i,
   input  logic                     wb_rst_i,
   input  logic [DIV_W-1:0]         clk_div,
   uart_tx_fifo_if.slave            tx_if,
   output logic                     tx_o,
   output logic                     busy,
   output logic                     tx_done,
   output logic [$clog2(DEPTH):0]   fifo_level
);

   uart_state_e      state_q, state_d;
   logic [7:0]       shift_q, shift_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_idx_q, bit_idx_d;
   logic             tx_q, tx_d;
   logic             done_q, done_d;
   logic             pop_s;
   logic             push_s;
   logic [7:0]       fifo_rdata_s;
   logic             fifo_full_s;
   logic             fifo_empty_s;
   logic [DIV_W-1:0] eff_div_s;

   // Divisors below the minimum would make bits shorter than two cycles.
   assign eff_div_s      = (clk_div < DIV_W'(UART_MIN_DIV)) ? DIV_W'(UART_MIN_DIV) : clk_div;
   assign tx_if.tx_ready = !fifo_full_s;
   assign push_s         = tx_if.tx_valid && !fifo_full_s;
   assign busy           = (state_q != IDLE) || !fifo_empty_s;
   assign tx_o           = tx_q;
   assign tx_done        = done_q;

   uart_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (wb_clk_i),
      .rst   (wb_rst_i),
      .push  (push_s),
      .wdata (tx_if.tx_data),
      .pop   (pop_s),
      .rdata (fifo_rdata_s),
      .full  (fifo_full_s),
      .empty (fifo_empty_s),
      .level (fifo_level)
   );

   // Frame sequencer: next state, bit timing, shifting and registered line level.
   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      div_d     = div_q;
      cnt_d     = cnt_q;
      bit_idx_d = bit_idx_q;
      pop_s     = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifo_empty_s) begin
               pop_s   = 1'b1;
               shift_d = fifo_rdata_s;
               div_d   = eff_div_s;
               cnt_d   = eff_div_s - DIV_W'(1);
               state_d = START;
            end else begin
               state_d = IDLE;
            end
         end
         START: begin
            if (cnt_q == DIV_W'(0)) begin
               cnt_d     = div_q - DIV_W'(1);
               bit_idx_d = 3'd0;
               state_d   = DATA;
            end else begin
               cnt_d = cnt_q - DIV_W'(1);
            end
         end
         DATA: begin
            if (cnt_q == DIV_W'(0)) begin
               cnt_d = div_q - DIV_W'(1);
               if (bit_idx_q == 3'(UART_DATA_BITS - 1)) begin
                  state_d = STOP;
               end else begin
                  shift_d   = {1'b0, shift_q[7:1]};
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q - DIV_W'(1);
            end
         end
         STOP: begin
            if (cnt_q == DIV_W'(0)) begin
               // Chain straight into the next frame when a byte is queued.
               if (!fifo_empty_s) begin
                  pop_s   = 1'b1;
                  shift_d = fifo_rdata_s;
                  div_d   = eff_div_s;
                  cnt_d   = eff_div_s - DIV_W'(1);
                  state_d = START;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q - DIV_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Line level and done pulse follow the state being entered, so the
      // registered outputs line up with the state registers.
      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[0];
         default: tx_d = 1'b1;
      endcase
      done_d = (state_d == STOP) && (cnt_d == DIV_W'(0));
   end

   // Sequencer registers; reset returns the line to idle-high immediately.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q   <= IDLE;
         shift_q   <= 8'h00;
         div_q     <= DIV_W'(UART_MIN_DIV);
         cnt_q     <= DIV_W'(0);
         bit_idx_q <= 3'd0;
         tx_q      <= 1'b1;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         div_q     <= div_d;
         cnt_q     <= cnt_d;
         bit_idx_q <= bit_idx_d;
         tx_q      <= tx_d;
         done_q    <= done_d;
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo. Cycle c of a scenario is the interval
// after the c-th rising edge; inputs are driven and outputs sampled 1 time
// unit after that edge.
module tb_uart_tx_fifo;
   import uart_pkg::*;

   logic        clk;
   logic        rst;
   logic [15:0] clk_div;
   logic        tx_o;
   logic        busy;
   logic        tx_done;
   logic [2:0]  fifo_level;
   int          n_vec;
   int          n_err;

   uart_tx_fifo_if bus ();

   uart_tx_fifo #(.DEPTH(4), .DIV_W(16)) dut (
      .wb_clk_i   (clk),
      .wb_rst_i   (rst),
      .clk_div    (clk_div),
      .tx_if      (bus),
      .tx_o       (tx_o),
      .busy       (busy),
      .tx_done    (tx_done),
      .fifo_level (fifo_level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected line level k cycles into a frame carrying byte b at divisor div.
   function automatic logic frame_bit(input logic [7:0] b, input int div, input int k);
      int slot;
      slot = k / div;
      if (slot == 0) return 1'b0;
      if (slot <= 8) return b[slot-1];
      return 1'b1;
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      bus.tx_valid = 1'b0;
      bus.tx_data = 8'h00;
      clk_div = 16'd4;
      tick();
      tick();
      rst = 1'b0;
      n_vec++;
      if ({tx_o, bus.tx_ready, busy, tx_done, fifo_level} !== {1'b1, 1'b1, 1'b0, 1'b0, 3'd0}) begin
         n_err++;
         $display("FAIL reset: tx_o/ready/busy/done/level = %b/%b/%b/%b/%0d, expected 1/1/0/0/0",
                  tx_o, bus.tx_ready, busy, tx_done, fifo_level);
      end
      tick();
   endtask

   task automatic test_single();
      logic exp_tx;
      clk_div = 16'd4;
      bus.tx_data = 8'hA5;
      bus.tx_valid = 1'b1;
      for (int c = 0; c <= 42; c++) begin
         if (c == 1) bus.tx_valid = 1'b0;
         exp_tx = (c >= 2 && c < 42) ? frame_bit(8'hA5, 4, c - 2) : 1'b1;
         n_vec++;
         if ({tx_o, tx_done} !== {exp_tx, (c == 41)}) begin
            n_err++;
            $display("FAIL single cycle %0d: tx_o/done = %b/%b, expected %b/%b", c, tx_o, tx_done, exp_tx, (c == 41));
         end
         if (c == 1 || c == 42) begin
            n_vec++;
            if (busy !== (c == 1)) begin
               n_err++;
               $display("FAIL single busy cycle %0d: got %b, expected %b", c, busy, (c == 1));
            end
         end
         if (c == 1) begin
            n_vec++;
            if (fifo_level !== 3'd1) begin
               n_err++;
               $display("FAIL single level cycle 1: got %0d, expected 1", fifo_level);
            end
         end
         tick();
      end
   endtask

   task automatic test_burst();
      logic [2:0] lvl_tbl [6];
      int         flen;
      logic       exp_tx;
      logic       exp_done;
      logic       exp_rdy;
      lvl_tbl = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4};
      flen = UART_FRAME_BITS * 8;
      clk_div = 16'd8;
      for (int c = 0; c <= 482; c++) begin
         bus.tx_valid = (c <= 82);
         bus.tx_data = (c <= 4) ? 8'(c + 1) : 8'h06;
         if (c <= 82) begin
            exp_rdy = (c < 5) || (c == 82);
            n_vec++;
            if (bus.tx_ready !== exp_rdy) begin
               n_err++;
               $display("FAIL burst ready cycle %0d: got %b, expected %b", c, bus.tx_ready, exp_rdy);
            end
         end
         if (c <= 5 || c == 82) begin
            n_vec++;
            if (fifo_level !== ((c == 82) ? 3'd3 : lvl_tbl[c])) begin
               n_err++;
               $display("FAIL burst level cycle %0d: got %0d, expected %0d", c, fifo_level,
                        (c == 82) ? 3'd3 : lvl_tbl[c]);
            end
         end
         if (c >= 2 && c < 2 + 6 * flen) begin
            exp_tx = frame_bit(8'((c - 2) / flen + 1), 8, (c - 2) % flen);
            exp_done = ((c - 2) % flen == flen - 1);
         end else begin
            exp_tx = 1'b1;
            exp_done = 1'b0;
         end
         n_vec++;
         if ({tx_o, tx_done} !== {exp_tx, exp_done}) begin
            n_err++;
            $display("FAIL burst line cycle %0d: tx_o/done = %b/%b, expected %b/%b", c, tx_o, tx_done, exp_tx, exp_done);
         end
         if (c == 482) begin
            n_vec++;
            if (busy !== 1'b0) begin
               n_err++;
               $display("FAIL burst busy end: got %b, expected 0", busy);
            end
         end
         tick();
      end
   endtask

   task automatic test_min_div();
      logic exp_tx;
      for (int dv = 0; dv <= 1; dv++) begin
         clk_div = 16'(dv);
         bus.tx_data = 8'hFF;
         bus.tx_valid = 1'b1;
         for (int c = 0; c <= 22; c++) begin
            if (c == 1) bus.tx_valid = 1'b0;
            exp_tx = (c >= 2 && c < 22) ? frame_bit(8'hFF, 2, c - 2) : 1'b1;
            n_vec++;
            if ({tx_o, tx_done} !== {exp_tx, (c == 21)}) begin
               n_err++;
               $display("FAIL min_div div=%0d cycle %0d: tx_o/done = %b/%b, expected %b/%b",
                        dv, c, tx_o, tx_done, exp_tx, (c == 21));
            end
            tick();
         end
      end
   endtask

   task automatic test_div_change();
      logic exp_tx;
      clk_div = 16'd4;
      for (int c = 0; c <= 102; c++) begin
         bus.tx_valid = (c <= 1);
         bus.tx_data = (c == 0) ? 8'h3C : 8'hC3;
         if (c == 10) clk_div = 16'd6;
         if (c >= 2 && c < 42) exp_tx = frame_bit(8'h3C, 4, c - 2);
         else if (c >= 42 && c < 102) exp_tx = frame_bit(8'hC3, 6, c - 42);
         else exp_tx = 1'b1;
         n_vec++;
         if ({tx_o, tx_done} !== {exp_tx, (c == 41 || c == 101)}) begin
            n_err++;
            $display("FAIL div_change cycle %0d: tx_o/done = %b/%b, expected %b/%b",
                     c, tx_o, tx_done, exp_tx, (c == 41 || c == 101));
         end
         if (c == 102) begin
            n_vec++;
            if (busy !== 1'b0) begin
               n_err++;
               $display("FAIL div_change busy end: got %b, expected 0", busy);
            end
         end
         tick();
      end
      clk_div = 16'd4;
   endtask

   task automatic test_reset_mid();
      logic exp_tx;
      clk_div = 16'd4;
      for (int c = 0; c <= 60; c++) begin
         bus.tx_valid = (c <= 1);
         bus.tx_data = (c == 0) ? 8'h55 : 8'hAA;
         rst = (c == 19);
         exp_tx = (c >= 2 && c < 20) ? frame_bit(8'h55, 4, c - 2) : 1'b1;
         n_vec++;
         if ({tx_o, tx_done} !== {exp_tx, 1'b0}) begin
            n_err++;
            $display("FAIL reset_mid line cycle %0d: tx_o/done = %b/%b, expected %b/0", c, tx_o, tx_done, exp_tx);
         end
         if (c >= 20) begin
            n_vec++;
            if ({busy, fifo_level} !== {1'b0, 3'd0}) begin
               n_err++;
               $display("FAIL reset_mid state cycle %0d: busy/level = %b/%0d, expected 0/0", c, busy, fifo_level);
            end
         end
         tick();
      end
      rst = 1'b0;
   endtask

   task automatic test_loopback();
      logic [7:0] msg [3];
      logic [7:0] rx [3];
      msg = '{8'h4F, 8'h4B, 8'h0A};
      clk_div = 16'd4;
      for (int i = 0; i < 3; i++) begin
         bus.tx_valid = 1'b1;
         bus.tx_data = msg[i];
         tick();
      end
      bus.tx_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         for (int w = 0; w < 200 && tx_o !== 1'b0; w++) tick();
         n_vec++;
         if (tx_o !== 1'b0) begin
            n_err++;
            $display("FAIL loopback start byte %0d: no start bit within 200 cycles", i);
         end
         tick();
         tick();
         for (int b = 0; b < 8; b++) begin
            repeat (4) tick();
            rx[i][b] = tx_o;
         end
         repeat (4) tick();
         n_vec++;
         if (tx_o !== 1'b1) begin
            n_err++;
            $display("FAIL loopback stop byte %0d: got %b, expected 1", i, tx_o);
         end
         n_vec++;
         if (rx[i] !== msg[i]) begin
            n_err++;
            $display("FAIL loopback byte %0d: got %h, expected %h", i, rx[i], msg[i]);
         end
      end
      $display("loopback received: %c%c", rx[0], rx[1]);
      repeat (10) tick();
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      rst = 1'b1;
      clk_div = 16'd4;
      bus.tx_valid = 1'b0;
      bus.tx_data = 8'h00;
      test_reset();
      test_single();
      test_burst();
      test_min_div();
      test_div_change();
      test_reset_mid();
      test_loopback();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- User-project-side 8N1 UART transmitter with a small byte FIFO in front of it.
- Drives mprj_io[6], the serial line the testbench UART receiver monitors. Firmware or user logic pushes bytes; the block serialises them LSB-first.
- Gives the user area its own debug and status channel, in parallel with the checkbits GPIOs.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- DIV_W, 16, width of the clk_div input.

Ports:
- wb_clk_i  in  1  system clock; all logic on rising edge.
- wb_rst_i  in  1  synchronous reset, active-high.
- clk_div  in  DIV_W  clock cycles per bit; values 0 and 1 are treated as 2.
- tx_data  in  8  byte to transmit.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  FIFO can accept a byte; equals !full.
- tx_o  out  1  serial output; idle high; registered.
- busy  out  1  high when the FIFO is non-empty or the FSM is not in IDLE.
- tx_done  out  1  one-cycle pulse in the last cycle of each stop bit.
- fifo_level  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (wb_clk_i, wb_rst_i).
- Reset values: tx_o=1, tx_ready=1, busy=0, tx_done=0, fifo_level=0, FSM=IDLE, FIFO pointers=0.
- Push: occurs when tx_valid && tx_ready on a rising edge. No push when full; there is no bypass, even if a pop happens in the same cycle.
- Pop: performed by the FSM only. A simultaneous push and pop leaves the level unchanged. Pointers wrap modulo DEPTH; level uses an extra bit to tell full from empty.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - tx_o=1.
  - If the FIFO is non-empty in cycle t, pop into shift_reg, latch div_q=max(clk_div,2), go to START.
  - A byte pushed into an empty FIFO at t-1 is therefore popped at t.
- START: tx_o=0 for div_q cycles (t+1..t+div_q), then go to DATA with bit_idx=0.
- DATA:
  - tx_o=shift_reg[0] for div_q cycles per bit; shift right after each bit.
  - After bit_idx=7, go to STOP.
- STOP:
  - tx_o=1 for div_q cycles; tx_done=1 in the last cycle.
  - In that same last cycle: if the FIFO is non-empty, pop, re-latch div_q, go to START (no idle gap between frames). Otherwise go to IDLE.
- Frame length is exactly 10*div_q cycles.
- clk_div changes mid-frame are ignored until the next frame latches the new value.
- Bit counter counts down from div_q-1 to 0, DIV_W bits wide, no overflow.
- Reset mid-frame: the next cycle has tx_o=1, FIFO flushed, FSM=IDLE, no tx_done pulse.
- tx_valid held with unchanged data while tx_ready=0 must not cause a duplicate push.

Decomposition:
- Shared package uart_pkg holds:
  - enum uart_state_e {IDLE, START, DATA, STOP};
  - constants UART_DATA_BITS=8, UART_FRAME_BITS=10, UART_MIN_DIV=2.
- One sub-module, uart_byte_fifo: synchronous FIFO with parameter DEPTH, push/pop/full/empty/level. The top instantiates it plus the FSM and shift/bit counters.

Test Plan:
- Single byte: reset, clk_div=4, push 0xA5 at cycle 0.
  - Expected pop at cycle 1.
  - tx_o from cycle 2 runs 0,1,0,1,0,0,1,0,1,1, each held 4 cycles.
  - tx_done high at cycle 41; busy low at cycle 42.
- Burst/full, DEPTH=4, clk_div=8: tx_valid held for 6 consecutive cycles with 0x01..0x06.
  - Exactly 5 bytes accepted; tx_ready=0 from cycle 5; 0x06 is held off until the first frame ends.
  - Frames are back-to-back: 0x01's stop bit is immediately followed by a start bit, and 6 frames total 480 cycles of tx_o activity.
- Minimum divisor: clk_div=0, then 1, send 0xFF.
  - Every bit is 2 cycles; frame is 20 cycles: 0 for 2 cycles, then 1 for 18.
- Divisor change mid-frame: clk_div=4, push 0x3C and 0xC3, set clk_div=6 during the DATA of frame 1.
  - Frame 1 takes 40 cycles; frame 2 takes 60 cycles.
- Reset mid-frame: push 0x55 and 0xAA; assert wb_rst_i for 1 cycle during data bit 3.
  - Next cycle: tx_o=1, fifo_level=0, busy=0.
  - No further frames; no tx_done pulse.
- Loopback: connect tx_o to mprj_io[6]; firmware sends "OK\n" at the standard divisor.
  - The testbench UART receiver prints "OK".
